// File: rtl/mem_access_formatter.sv
// -----------------------------------------------------------------------------
// mem_access_formatter
//
// Datapath helper sitting between the data cache RAM and the CPU pipeline.
// It performs the two formatting jobs a RV32I load/store unit needs, selected
// by the instruction's funct3 field:
//
//   * Load formatting  - picks the addressed byte / halfword / word out of the
//                        raw 32-bit memory word, right-aligns it and sign- or
//                        zero-extends it for the register file.
//   * Store formatting - replicates the store data into every byte lane it may
//                        land in and produces the byte-write strobes used by
//                        the cache RAM and the Wishbone sel lines.
//
// It also flags accesses that are not naturally aligned. Misaligned accesses
// are still formatted (halfword uses addr_lo_i[1] only, word ignores the
// address); raising an exception is the pipeline's job, not ours.
//
// Build option:
//   FMT_OUT_REG_EN  - when defined, every output is registered on the rising
//                     edge of cpu_clock_i (exactly one cycle of latency) and
//                     asynchronously forced to zero while cpu_rst_ni is low.
//                     When undefined (default) the block is purely
//                     combinational, valid_o = valid_i, and the clock and
//                     reset inputs are unused.
//
// Ports:
//   cpu_clock_i  in   1   clock, rising edge (registered build only)
//   cpu_rst_ni   in   1   asynchronous active-low reset (registered build only)
//   valid_i      in   1   a memory operation is presented this cycle
//   ld_word_i    in   32  raw word read from cache RAM / memory
//   st_data_i    in   32  store data from rs2 (low bits significant)
//   addr_lo_i    in   2   byte address bits [1:0]
//   funct3_i     in   3   instr[14:12]; loads use all bits, stores use [1:0]
//   ld_data_o    out  32  formatted load result
//   st_word_o    out  32  lane-replicated store data
//   st_sel_o     out  4   byte-write strobes, bit k enables bits [8k+7:8k]
//   misalign_o   out  1   access is not naturally aligned
//   valid_o      out  1   outputs are valid
// -----------------------------------------------------------------------------
module mem_access_formatter (
   input  logic        cpu_clock_i,
   input  logic        cpu_rst_ni,
   input  logic        valid_i,
   input  logic [31:0] ld_word_i,
   input  logic [31:0] st_data_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] st_word_o,
   output logic [3:0]  st_sel_o,
   output logic        misalign_o,
   output logic        valid_o
);

   // funct3 encodings for loads (full 3 bits)
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // access size encodings (funct3[1:0]), shared by loads and stores
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [1:0]  access_size;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data_c;
   logic [31:0] st_word_c;
   logic [3:0]  st_sel_c;
   logic        misalign_c;

   assign access_size = funct3_i[1:0];

   // Select the addressed byte lane of the memory word. A case on the two
   // address bits keeps this a plain 4:1 mux rather than a barrel shifter.
   always_comb begin
      ld_byte = ld_word_i[7:0];
      case (addr_lo_i)
         2'd0: ld_byte = ld_word_i[7:0];
         2'd1: ld_byte = ld_word_i[15:8];
         2'd2: ld_byte = ld_word_i[23:16];
         2'd3: ld_byte = ld_word_i[31:24];
         default: ld_byte = ld_word_i[7:0];
      endcase
   end

   // Halfword selection only looks at addr_lo_i[1]; a misaligned halfword
   // (addr_lo_i[0] set) is deliberately formatted as if it were aligned down.
   assign ld_half = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

   // Load result: extend the selected byte/halfword. The signed variants
   // replicate the top bit of the selected field; unused encodings and LW
   // hand the raw word straight through.
   always_comb begin
      ld_data_c = ld_word_i;
      case (funct3_i)
         F3_LB:   ld_data_c = {{24{ld_byte[7]}}, ld_byte};
         F3_LBU:  ld_data_c = {24'h000000, ld_byte};
         F3_LH:   ld_data_c = {{16{ld_half[15]}}, ld_half};
         F3_LHU:  ld_data_c = {16'h0000, ld_half};
         F3_LW:   ld_data_c = ld_word_i;
         default: ld_data_c = ld_word_i;
      endcase
   end

   // Store data is replicated into every lane it could land in, so the RAM
   // only has to honour the strobes; the strobes pick the real destination.
   // Size 11 is not a legal store: data passes through with no lanes enabled.
   always_comb begin
      st_word_c = st_data_i;
      st_sel_c  = 4'b0000;
      case (access_size)
         SZ_BYTE: begin
            st_word_c = {4{st_data_i[7:0]}};
            st_sel_c  = 4'b0001 << addr_lo_i;
         end
         SZ_HALF: begin
            st_word_c = {2{st_data_i[15:0]}};
            st_sel_c  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
         end
         SZ_WORD: begin
            st_word_c = st_data_i;
            st_sel_c  = 4'b1111;
         end
         default: begin
            st_word_c = st_data_i;
            st_sel_c  = 4'b0000;
         end
      endcase
   end

   // Natural alignment check: bytes are always aligned, halfwords need an
   // even address, words need address bits [1:0] = 0. Size 11 never flags.
   always_comb begin
      misalign_c = 1'b0;
      case (access_size)
         SZ_HALF: misalign_c = addr_lo_i[0];
         SZ_WORD: misalign_c = (addr_lo_i != 2'b00);
         default: misalign_c = 1'b0;
      endcase
   end

`ifdef FMT_OUT_REG_EN

   // Output register stage. Data registers load every cycle regardless of
   // valid_i, and valid_o is simply valid_i delayed by one cycle. Reset is
   // asynchronous so the strobes drop to zero the moment reset asserts and no
   // stray write can reach the RAM; any in-flight result is discarded.
   always_ff @(posedge cpu_clock_i or negedge cpu_rst_ni) begin
      if (!cpu_rst_ni) begin
         ld_data_o  <= 32'h0000_0000;
         st_word_o  <= 32'h0000_0000;
         st_sel_o   <= 4'b0000;
         misalign_o <= 1'b0;
         valid_o    <= 1'b0;
      end else begin
         ld_data_o  <= ld_data_c;
         st_word_o  <= st_word_c;
         st_sel_o   <= st_sel_c;
         misalign_o <= misalign_c;
         valid_o    <= valid_i;
      end
   end

`else

   // Combinational build: zero latency, outputs track inputs even while the
   // reset input is asserted. Clock and reset are folded into a dummy signal
   // so they are visibly consumed without affecting any output.
   logic unused_clock_reset;
   assign unused_clock_reset = cpu_clock_i ^ cpu_rst_ni;

   assign ld_data_o  = ld_data_c;
   assign st_word_o  = st_word_c;
   assign st_sel_o   = st_sel_c;
   assign misalign_o = misalign_c;
   assign valid_o    = valid_i;

`endif

endmodule

// File: tb/tb_mem_access_formatter.sv
// -----------------------------------------------------------------------------
// tb_mem_access_formatter
//
// Self-checking bench for mem_access_formatter. Expected values come from a
// small behavioural model expressed with plain arithmetic on byte/halfword
// values. Works for both the default combinational build and the
// FMT_OUT_REG_EN registered build (define the macro for both files).
// -----------------------------------------------------------------------------
module tb_mem_access_formatter;

   logic        cpu_clock_i;
   logic        cpu_rst_ni;
   logic        valid_i;
   logic [31:0] ld_word_i;
   logic [31:0] st_data_i;
   logic [1:0]  addr_lo_i;
   logic [2:0]  funct3_i;
   logic [31:0] ld_data_o;
   logic [31:0] st_word_o;
   logic [3:0]  st_sel_o;
   logic        misalign_o;
   logic        valid_o;

   int vectors;
   int miscompares;

   mem_access_formatter dut (
      .cpu_clock_i (cpu_clock_i),
      .cpu_rst_ni  (cpu_rst_ni),
      .valid_i     (valid_i),
      .ld_word_i   (ld_word_i),
      .st_data_i   (st_data_i),
      .addr_lo_i   (addr_lo_i),
      .funct3_i    (funct3_i),
      .ld_data_o   (ld_data_o),
      .st_word_o   (st_word_o),
      .st_sel_o    (st_sel_o),
      .misalign_o  (misalign_o),
      .valid_o     (valid_o)
   );

   // 10-time-unit clock
   initial begin
      cpu_clock_i = 1'b0;
      forever #5 cpu_clock_i = ~cpu_clock_i;
   end

   // ---------------- reference model ----------------

   // Load result from byte/halfword values using integer arithmetic.
   function automatic logic [31:0] exp_ld(logic [31:0] w, int f3, int a);
      longint v;
      case (f3)
         0, 4: begin
            v = longint'((w >> (8 * a)) % 256);
            if (f3 == 0 && v >= 128) v = v - 256;
         end
         1, 5: begin
            v = longint'((w >> (16 * (a / 2))) % 65536);
            if (f3 == 1 && v >= 32768) v = v - 65536;
         end
         default: v = longint'(w);
      endcase
      return v[31:0];
   endfunction

   function automatic logic [31:0] exp_st_word(logic [31:0] d, int f3);
      logic [31:0] r;
      case (f3 % 4)
         0:       r = (d % 256) * 32'h0101_0101;
         1:       r = (d % 65536) * 32'h0001_0001;
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] exp_sel(int f3, int a);
      int r;
      case (f3 % 4)
         0:       r = 2 ** a;
         1:       r = (a >= 2) ? 12 : 3;
         2:       r = 15;
         default: r = 0;
      endcase
      return r[3:0];
   endfunction

   function automatic logic exp_mis(int f3, int a);
      case (f3 % 4)
         1:       return (a % 2) == 1;
         2:       return a != 0;
         default: return 1'b0;
      endcase
   endfunction

   // Present one vector and wait until its result should be visible.
   task automatic drive(input logic v, input logic [31:0] lw, input logic [31:0] sd,
                        input logic [1:0] a, input logic [2:0] f3);
      valid_i   = v;
      ld_word_i = lw;
      st_data_i = sd;
      addr_lo_i = a;
      funct3_i  = f3;
`ifdef FMT_OUT_REG_EN
      @(posedge cpu_clock_i);
      #1;
`else
      #2;
`endif
   endtask

   // ---------------- tests ----------------

   task automatic test_reset();
      cpu_rst_ni = 1'b0;
      valid_i    = 1'b1;
      ld_word_i  = 32'h8F7E_6D5C;
      st_data_i  = 32'h1234_56AB;
      addr_lo_i  = 2'd3;
      funct3_i   = 3'b000;
      #12;
`ifdef FMT_OUT_REG_EN
      vectors++;
      if ({ld_data_o, st_word_o, st_sel_o, misalign_o, valid_o} !== 70'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got %h/%h/%b/%b/%b required all zero",
                  ld_data_o, st_word_o, st_sel_o, misalign_o, valid_o);
      end
`else
      vectors++;
      if (ld_data_o !== 32'hFFFF_FF8F || st_sel_o !== 4'b1000 || valid_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_passthrough: got %h/%b/%b required ffffff8f/1000/1",
                  ld_data_o, st_sel_o, valid_o);
      end
`endif
      @(negedge cpu_clock_i);
      cpu_rst_ni = 1'b1;
      valid_i    = 1'b0;
      #1;
   endtask

   task automatic test_byte_loads();
      logic [31:0] expv [5];
      expv = '{32'h0000_005C, 32'h0000_006D, 32'h0000_007E, 32'hFFFF_FF8F, 32'h0000_008F};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h8F7E_6D5C, 32'h0, (i == 4) ? 2'd3 : 2'(i), (i == 4) ? 3'b100 : 3'b000);
         vectors++;
         if (ld_data_o !== expv[i]) begin
            miscompares++;
            $display("[TB] FAIL byte_load[%0d]: got %h required %h", i, ld_data_o, expv[i]);
         end
      end
   endtask

   task automatic test_half_loads();
      logic [2:0]  f3s  [4];
      logic [1:0]  adrs [4];
      logic [31:0] expv [4];
      logic        expm [4];
      f3s  = '{3'b001, 3'b001, 3'b101, 3'b001};
      adrs = '{2'd0, 2'd2, 2'd2, 2'd1};
      expv = '{32'h0000_7FFF, 32'hFFFF_8001, 32'h0000_8001, 32'h0000_7FFF};
      expm = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h8001_7FFF, 32'h0, adrs[i], f3s[i]);
         vectors++;
         if (ld_data_o !== expv[i] || misalign_o !== expm[i]) begin
            miscompares++;
            $display("[TB] FAIL half_load[%0d]: got %h mis=%b required %h mis=%b",
                     i, ld_data_o, misalign_o, expv[i], expm[i]);
         end
      end
   endtask

   task automatic test_word_load();
      drive(1'b1, 32'hDEAD_BEEF, 32'h0, 2'd2, 3'b010);
      vectors++;
      if (ld_data_o !== 32'hDEAD_BEEF || misalign_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL word_load: got %h mis=%b required deadbeef mis=1",
                  ld_data_o, misalign_o);
      end
   endtask

   task automatic test_stores();
      logic [2:0]  f3s  [4];
      logic [1:0]  adrs [4];
      logic [31:0] expw [4];
      logic [3:0]  exps [4];
      f3s  = '{3'b000, 3'b001, 3'b010, 3'b011};
      adrs = '{2'd2, 2'd2, 2'd0, 2'd0};
      expw = '{32'hABAB_ABAB, 32'h56AB_56AB, 32'h1234_56AB, 32'h1234_56AB};
      exps = '{4'b0100, 4'b1100, 4'b1111, 4'b0000};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h0, 32'h1234_56AB, adrs[i], f3s[i]);
         vectors++;
         if (st_word_o !== expw[i] || st_sel_o !== exps[i] || misalign_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL store[%0d]: got %h sel=%b mis=%b required %h sel=%b mis=0",
                     i, st_word_o, st_sel_o, misalign_o, expw[i], exps[i]);
         end
      end
   endtask

   // All funct3 x address combinations, several rounds of random data.
   task automatic test_sweep();
      logic [31:0] w, d;
      logic        v;
      logic [69:0] got, req;
      for (int r = 0; r < 4; r++) begin
         for (int f = 0; f < 8; f++) begin
            for (int a = 0; a < 4; a++) begin
               w = $urandom;
               d = $urandom;
               v = 1'($urandom_range(0, 1));
               drive(v, w, d, 2'(a), 3'(f));
               req = {exp_ld(w, f, a), exp_st_word(d, f), exp_sel(f, a), exp_mis(f, a), v};
               got = {ld_data_o, st_word_o, st_sel_o, misalign_o, valid_o};
               vectors++;
               if (got !== req) begin
                  miscompares++;
                  $display("[TB] FAIL sweep f3=%0d a=%0d: got %h required %h", f, a, got, req);
               end
            end
         end
      end
   endtask

`ifdef FMT_OUT_REG_EN
   // Outputs must hold the previous result until the next rising edge.
   task automatic test_latency();
      drive(1'b1, 32'h8F7E_6D5C, 32'h0, 2'd0, 3'b000);
      valid_i   = 1'b0;
      addr_lo_i = 2'd3;
      #1;
      vectors++;
      if (ld_data_o !== 32'h0000_005C || valid_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL latency_hold: got %h v=%b required 0000005c v=1", ld_data_o, valid_o);
      end
      @(posedge cpu_clock_i);
      #1;
      vectors++;
      if (ld_data_o !== 32'hFFFF_FF8F || valid_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL latency_update: got %h v=%b required ffffff8f v=0", ld_data_o, valid_o);
      end
   endtask

   // Mid-cycle reset clears outputs at once; first valid follows release.
   task automatic test_reset_mid();
      drive(1'b1, 32'hDEAD_BEEF, 32'h1234_56AB, 2'd0, 3'b010);
      #3;
      cpu_rst_ni = 1'b0;
      #1;
      vectors++;
      if ({ld_data_o, st_word_o, st_sel_o, misalign_o, valid_o} !== 70'd0) begin
         miscompares++;
         $display("[TB] FAIL async_reset: got %h/%h/%b/%b/%b required all zero",
                  ld_data_o, st_word_o, st_sel_o, misalign_o, valid_o);
      end
      @(negedge cpu_clock_i);
      cpu_rst_ni = 1'b1;
      drive(1'b0, 32'hDEAD_BEEF, 32'h1234_56AB, 2'd0, 3'b010);
      vectors++;
      if (valid_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL release_idle: got valid %b required 0", valid_o);
      end
      drive(1'b1, 32'hDEAD_BEEF, 32'h1234_56AB, 2'd0, 3'b010);
      vectors++;
      if (valid_o !== 1'b1 || st_sel_o !== 4'b1111 || ld_data_o !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("[TB] FAIL release_first_valid: got v=%b sel=%b %h required v=1 sel=1111 deadbeef",
                  valid_o, st_sel_o, ld_data_o);
      end
   endtask
`endif

   // Consecutive random vectors with no idle gap between them.
   task automatic test_back_to_back();
      logic [31:0] w, d;
      int f, a;
      for (int i = 0; i < 16; i++) begin
         w = $urandom;
         d = $urandom;
         f = $urandom_range(0, 7);
         a = $urandom_range(0, 3);
         drive(1'b1, w, d, 2'(a), 3'(f));
         vectors++;
         if (ld_data_o !== exp_ld(w, f, a) || st_word_o !== exp_st_word(d, f) ||
             st_sel_o !== exp_sel(f, a) || valid_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL back_to_back[%0d]: got %h %h %b required %h %h %b", i,
                     ld_data_o, st_word_o, st_sel_o,
                     exp_ld(w, f, a), exp_st_word(d, f), exp_sel(f, a));
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cpu_rst_ni  = 1'b0;
      valid_i     = 1'b0;
      ld_word_i   = '0;
      st_data_i   = '0;
      addr_lo_i   = '0;
      funct3_i    = '0;
      test_reset();
      test_byte_loads();
      test_half_loads();
      test_word_load();
      test_stores();
      test_sweep();
`ifdef FMT_OUT_REG_EN
      test_latency();
      test_reset_mid();
`endif
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
